// File: rtl/mult_sched_pkg.sv
// Shared types and helpers for the shared-multiplier scheduler.
package mult_sched_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  typedef logic [OP_W-1:0]   op_t;
  typedef logic [PROD_W-1:0] prod_t;

  // Cyclic increment of a requester index in the range 0..n-1.
  function automatic int next_ptr(input int cur, input int n);
    return (cur + 1 >= n) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/eightbitmultiplier.sv
// Combinational 8x8 unsigned array multiplier, exact 16-bit product.
module eightbitmultiplier
  import mult_sched_pkg::*;
(
  input  op_t   a,
  input  op_t   b,
  output prod_t prod
);

  // Sum of shifted partial products, one row per bit of b.
  always_comb begin
    prod = '0;
    for (int i = 0; i < OP_W; i++) begin
      prod = prod + ((PROD_W'(a) & {PROD_W{b[i]}}) << i);
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, cyclically.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             enable,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  winner
);

  logic found;

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
        grant[idx] = enable;
      end
    end
  end

endmodule

// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one 8x8 multiplier among N_REQ requesters,
// with a single registered result port.
module mult_share_sched
  import mult_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*8-1:0]   req_a,
  input  logic [N_REQ*8-1:0]   req_b,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [15:0]          resp_prod,
  output logic [ID_W-1:0]      resp_id,
  output logic [CNT_W-1:0]     op_count
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; valid never waits on ready, and ready here may depend
  // combinationally on resp_ready so a full result register drains and
  // refills in the same cycle.

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] winner;
  logic            can_accept;
  logic            grant_en;
  logic            req_fire;
  logic            resp_fire;
  op_t             op_a;
  op_t             op_b;
  prod_t           prod;

  assign can_accept = !resp_valid || resp_ready;
  // rst_n gates the grant so no requester sees ready while reset is held.
  assign grant_en   = can_accept && rst_n;
  assign req_fire   = |(req_valid & req_ready);
  assign resp_fire  = resp_valid && resp_ready;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .enable (grant_en),
    .grant  (req_ready),
    .winner (winner)
  );

  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_ready[i]) begin
        op_a = req_a[i*8 +: 8];
        op_b = req_b[i*8 +: 8];
      end
    end
  end

  eightbitmultiplier u_mul (
    .a    (op_a),
    .b    (op_b),
    .prod (prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_prod  <= '0;
      resp_id    <= '0;
      rr_ptr     <= '0;
      op_count   <= '0;
    end else begin
      if (req_fire) begin
        resp_valid <= 1'b1;
        resp_prod  <= prod;
        resp_id    <= winner;
        rr_ptr     <= ID_W'(next_ptr(int'(winner), N_REQ));
      end else if (resp_fire) begin
        resp_valid <= 1'b0;
      end
      if (resp_fire) begin
        op_count <= op_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mult_share_sched.sv
// Directed self-checking bench for mult_share_sched (4 requesters, 4-bit counter).
module tb_mult_share_sched;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;
  localparam int CNT_W = 4;

  logic               clk;
  logic               rst_n;
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*8-1:0] req_a;
  logic [N_REQ*8-1:0] req_b;
  logic [N_REQ-1:0]   req_ready;
  logic               resp_valid;
  logic               resp_ready;
  logic [15:0]        resp_prod;
  logic [ID_W-1:0]    resp_id;
  logic [CNT_W-1:0]   op_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [15:0] rr_prod [4];

  mult_share_sched #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_prod  (resp_prod),
    .resp_id    (resp_id),
    .op_count   (op_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 4'hF;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;

    // reset with every requester asserting valid
    repeat (3) tick();
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_op_count", 32'(op_count), 32'h0);
    check("rst_resp_prod", 32'(resp_prod), 32'h0);
    rst_n = 1'b1;
    #1;
    check("first_grant", 32'(req_ready), 32'h1);
    req_valid = 4'h0;

    // single op from requester 1
    set_op(1, 8'd40, 8'd38);
    req_valid = 4'b0010;
    #1;
    check("single_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'h0;
    #1;
    check("single_valid", 32'(resp_valid), 32'h1);
    check("single_prod", 32'(resp_prod), 32'd1520);
    check("single_id", 32'(resp_id), 32'd1);
    check("single_cnt0", 32'(op_count), 32'd0);
    tick();
    check("single_drain", 32'(resp_valid), 32'h0);
    check("single_cnt1", 32'(op_count), 32'd1);

    // requester 3 alone: moves rr_ptr from 2 back to 0
    set_op(3, 8'd7, 8'd9);
    req_valid = 4'b1000;
    tick();
    req_valid = 4'h0;
    check("r3_id", 32'(resp_id), 32'd3);
    check("r3_prod", 32'(resp_prod), 32'd63);
    tick();
    check("r3_cnt", 32'(op_count), 32'd2);

    // round-robin with all requesters valid
    set_op(0, 8'd255, 8'd255); rr_prod[0] = 16'd65025;
    set_op(1, 8'd0,   8'd255); rr_prod[1] = 16'd0;
    set_op(2, 8'd17,  8'd3);   rr_prod[2] = 16'd51;
    set_op(3, 8'd16,  8'd16);  rr_prod[3] = 16'd256;
    req_valid = 4'hF;
    #1;
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(32'(k % 4));
      check("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
      tick();
      begin
        logic [31:0] exp_id;
        exp_id = exp_q.pop_front();
        check("rr_valid", 32'(resp_valid), 32'h1);
        check("rr_id", 32'(resp_id), exp_id);
        check("rr_prod", 32'(resp_prod), 32'(rr_prod[exp_id[1:0]]));
      end
    end
    req_valid = 4'h0;
    tick();
    check("rr_cnt", 32'(op_count), 32'd10);
    check("rr_drain", 32'(resp_valid), 32'h0);

    // backpressure with 2*1 pending
    resp_ready = 1'b0;
    set_op(2, 8'd2, 8'd1);
    req_valid = 4'b0100;
    #1;
    check("bp_grant", 32'(req_ready), 32'b0100);
    tick();
    set_op(3, 8'd5, 8'd5);
    req_valid = 4'hF;
    for (int s = 0; s < 5; s++) begin
      #1;
      check("bp_ready", 32'(req_ready), 32'h0);
      check("bp_valid", 32'(resp_valid), 32'h1);
      check("bp_prod", 32'(resp_prod), 32'd2);
      check("bp_id", 32'(resp_id), 32'd2);
      tick();
    end
    check("bp_cnt_hold", 32'(op_count), 32'd10);
    resp_ready = 1'b1;
    #1;
    check("bp_release_grant", 32'(req_ready), 32'b1000);
    tick();
    req_valid = 4'h0;
    check("bp_new_valid", 32'(resp_valid), 32'h1);
    check("bp_new_id", 32'(resp_id), 32'd3);
    check("bp_new_prod", 32'(resp_prod), 32'd25);
    check("bp_cnt", 32'(op_count), 32'd11);
    tick();
    check("bp_cnt2", 32'(op_count), 32'd12);

    // skip idle requesters: rr_ptr=1, only 3 and 0 valid
    set_op(0, 8'd3, 8'd4);
    req_valid = 4'b0001;
    tick();
    req_valid = 4'h0;
    tick();
    req_valid = 4'b1001;
    #1;
    check("skip_grant3", 32'(req_ready), 32'b1000);
    tick();
    req_valid = 4'b0001;
    #1;
    check("skip_id3", 32'(resp_id), 32'd3);
    check("skip_grant0", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'h0;
    check("skip_id0", 32'(resp_id), 32'd0);
    check("skip_prod0", 32'(resp_prod), 32'd12);
    check("skip_cnt", 32'(op_count), 32'd14);
    tick();
    check("cnt_15", 32'(op_count), 32'd15);

    // counter wrap 15 -> 0
    req_valid = 4'b0001;
    tick();
    req_valid = 4'h0;
    tick();
    check("cnt_wrap", 32'(op_count), 32'd0);

    // async reset while a result is pending
    resp_ready = 1'b0;
    set_op(1, 8'd200, 8'd2);
    req_valid = 4'b0010;
    tick();
    req_valid = 4'hF;
    check("mid_valid", 32'(resp_valid), 32'h1);
    check("mid_prod", 32'(resp_prod), 32'd400);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_valid", 32'(resp_valid), 32'h0);
    check("async_prod", 32'(resp_prod), 32'h0);
    check("async_ready", 32'(req_ready), 32'h0);
    repeat (2) tick();
    req_valid  = 4'h0;
    resp_ready = 1'b1;
    rst_n      = 1'b1;
    tick();
    check("post_rst_valid", 32'(resp_valid), 32'h0);
    check("post_rst_cnt", 32'(op_count), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
